// File: rtl/adder_seq_pkg.sv
// Shared types and default timing constants for the adder measurement sequencer.
package adder_seq_pkg;

  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_DRAIN_CYCLES  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detect flop.
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset, clears all three flops
//   d     - asynchronous input
//   rise  - one-cycle pulse per synchronised 0->1 transition
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchroniser pair plus delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/adder_measure_sequencer.sv
// Sequences one delay measurement of the instrumented adder: latches operands,
// waits for them to settle, gates the ring oscillator for a programmed number
// of cycles and counts ring-output rising edges during the gate plus a drain.
// Ports:
//   wb_clk_i    - sole clock
//   rst_n       - synchronous active-low reset
//   active      - project select; low cancels any run
//   start       - single-cycle run request (honoured only when idle)
//   abort       - cancel run in progress
//   a_cfg/b_cfg - operands, latched at start
//   gate_cycles - ring-enable length, latched at start
//   chain_out   - asynchronous ring output from the adder
//   a_input/b_input - operands driven to the adder
//   ring_en     - closes the ring loop (high only in RUN)
//   busy        - run in progress
//   done        - sticky flag, last run completed normally
//   count       - measured rising-edge count
//   overflow    - count saturated
module adder_measure_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              active,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  a_cfg,
  input  logic [WIDTH-1:0]  b_cfg,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              chain_out,
  output logic [WIDTH-1:0]  a_input,
  output logic [WIDTH-1:0]  b_input,
  output logic              ring_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // One down-counter times settle, gate and drain, so it must hold the largest.
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DRN_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TMR_W0 = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam int unsigned TMR_W  = (TMR_W0 > DRN_W) ? TMR_W0 : DRN_W;

  seq_state_t         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [WIDTH-1:0]   a_d, b_d;
  logic [CNT_W-1:0]   count_d;
  logic               overflow_d;
  logic               ring_en_d;
  logic               busy_d;
  logic               done_d;
  logic               rise;
  logic               start_ok;
  logic               cancel;
  logic               finish;

  sync_rise_detect u_rise (
    .clk  (wb_clk_i),
    .rst_n(rst_n),
    .d    (chain_out),
    .rise (rise)
  );

  // Next-state, timer and registered-output computation.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    gate_d     = gate_q;
    a_d        = a_input;
    b_d        = b_input;
    count_d    = count;
    overflow_d = overflow;
    done_d     = done;
    finish     = 1'b0;
    start_ok   = 1'b0;
    cancel     = (state_q != IDLE) && (abort || !active);

    unique case (state_q)
      IDLE: begin
        if (start && active && !abort) begin
          start_ok = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = SETTLE;
        tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          // A zero gate skips RUN so the ring is never enabled.
          if (gate_q == '0) begin
            state_d = DRAIN;
            tmr_d   = TMR_W'(DRAIN_CYCLES - 1);
          end else begin
            state_d = RUN;
            tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RUN: begin
        if (tmr_q == '0) begin
          state_d = DRAIN;
          tmr_d   = TMR_W'(DRAIN_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Cancellation overrides every other transition; done stays clear.
    if (cancel) begin
      state_d = IDLE;
      finish  = 1'b0;
    end

    if (start_ok) begin
      a_d        = a_cfg;
      b_d        = b_cfg;
      gate_d     = gate_cycles;
      done_d     = 1'b0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (rise && (state_q == RUN || state_q == DRAIN)) begin
      // Saturate at all-ones and flag the lost edge.
      if (&count) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count + CNT_W'(1);
      end
    end

    if (finish) begin
      done_d = 1'b1;
    end

    ring_en_d = (state_d == RUN);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      gate_q   <= '0;
      a_input  <= '0;
      b_input  <= '0;
      ring_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      gate_q   <= gate_d;
      a_input  <= a_d;
      b_input  <= b_d;
      ring_en  <= ring_en_d;
      busy     <= busy_d;
      done     <= done_d;
      count    <= count_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Self-checking bench for adder_measure_sequencer with randomized runs and a
// rise-list reference model of the ring output.
module tb_adder_measure_sequencer;

  localparam int S = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        active;
  logic        start;
  logic        abort;
  logic [31:0] a_cfg;
  logic [31:0] b_cfg;
  logic [15:0] gate_cycles;
  logic        chain_out;
  logic [31:0] a_input, b_input;
  logic        ring_en, busy, done, overflow;
  logic [31:0] count;
  logic [31:0] s_a_input, s_b_input;
  logic        s_ring_en, s_busy, s_done, s_overflow;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;
  bit mode_rand = 1'b0;
  int rise_q[$];

  adder_measure_sequencer dut (
    .wb_clk_i(clk), .rst_n(rst_n), .active(active), .start(start), .abort(abort),
    .a_cfg(a_cfg), .b_cfg(b_cfg), .gate_cycles(gate_cycles), .chain_out(chain_out),
    .a_input(a_input), .b_input(b_input), .ring_en(ring_en), .busy(busy),
    .done(done), .count(count), .overflow(overflow)
  );

  adder_measure_sequencer #(.CNT_W(4)) dut_sat (
    .wb_clk_i(clk), .rst_n(rst_n), .active(active), .start(start), .abort(abort),
    .a_cfg(a_cfg), .b_cfg(b_cfg), .gate_cycles(gate_cycles), .chain_out(chain_out),
    .a_input(s_a_input), .b_input(s_b_input), .ring_en(s_ring_en), .busy(s_busy),
    .done(s_done), .count(s_count), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  // Ring model: while ring_en is high, drive either a toggle every 2 cycles or
  // random levels; record the gate-cycle index of every rising transition.
  initial begin
    int  n;
    logic v;
    n = 0;
    chain_out = 1'b0;
    forever begin
      @(negedge clk);
      if (ring_en) begin
        n++;
        if (mode_rand) v = 1'($urandom % 2);
        else v = (n % 2 == 1) ? ~chain_out : chain_out;
        if (v && !chain_out) rise_q.push_back(n);
        chain_out = v;
      end else begin
        n = 0;
        chain_out = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Launches a run at the current negedge and waits (bounded) for done.
  // lat = cycles from start edge until done visible (-1 on timeout).
  task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [15:0] g,
                        input int poke_at, output int lat, output int ring, output int first);
    int cyc;
    a_cfg = a; b_cfg = b; gate_cycles = g; start = 1'b1;
    rise_q.delete();
    @(negedge clk);
    start = 1'b0;
    a_cfg = $urandom; b_cfg = $urandom; gate_cycles = 16'($urandom);
    cyc = 0; ring = 0; first = -1;
    while (!done && cyc < 2000) begin
      start = (cyc == poke_at);
      if (ring_en) begin
        ring++;
        if (first < 0) first = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat = done ? cyc : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; active = 1'b1; start = 1'b0; abort = 1'b0;
    a_cfg = '0; b_cfg = '0; gate_cycles = '0;
    repeat (3) @(negedge clk);
    checks++; if (a_input !== 32'd0 || b_input !== 32'd0) begin errors++; $display("FAIL reset_operands: a=%h b=%h expected 0", a_input, b_input); end
    checks++; if (ring_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: ring_en=%b busy=%b done=%b expected 000", ring_en, busy, done); end
    checks++; if (count !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_count: count=%0d ovf=%b expected 0 0", count, overflow); end
    checks++; if (s_count !== 4'd0 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_sat: count=%0d busy=%b expected 0 0", s_count, s_busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, ring, first;
    mode_rand = 1'b0;
    do_run(32'h0000FFFF, 32'd1, 16'd40, -1, lat, ring, first);
    checks++; if (lat !== 48) begin errors++; $display("FAIL basic_latency: got %0d expected 48", lat); end
    checks++; if (ring !== 40) begin errors++; $display("FAIL basic_ring_cycles: got %0d expected 40", ring); end
    checks++; if (first !== S + 1) begin errors++; $display("FAIL basic_ring_start: got %0d expected %0d", first, S + 1); end
    checks++; if (count !== 32'd10 || rise_q.size() != 10) begin errors++; $display("FAIL basic_count: got %0d expected 10", count); end
    checks++; if (a_input !== 32'h0000FFFF || b_input !== 32'd1) begin errors++; $display("FAIL basic_operands: a=%h b=%h expected 0000ffff 00000001", a_input, b_input); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b ovf=%b expected 0 0", busy, overflow); end
  endtask

  task automatic test_zero_gate();
    int lat, ring, first;
    do_run(32'hA5A5A5A5, 32'h5A5A5A5A, 16'd0, -1, lat, ring, first);
    checks++; if (lat !== 8) begin errors++; $display("FAIL zero_latency: got %0d expected 8", lat); end
    checks++; if (ring !== 0) begin errors++; $display("FAIL zero_ring: got %0d expected 0", ring); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
  endtask

  task automatic test_random();
    int lat, ring, first;
    logic [31:0] a, b;
    logic [15:0] g;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; g = 16'($urandom_range(1, 60));
      mode_rand = 1'($urandom % 2);
      do_run(a, b, g, -1, lat, ring, first);
      checks++; if (lat !== S + int'(g) + D + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, S + int'(g) + D + 1); end
      checks++; if (ring !== int'(g)) begin errors++; $display("FAIL rand_ring[%0d]: got %0d expected %0d", i, ring, g); end
      checks++; if (count !== 32'(rise_q.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, rise_q.size()); end
      checks++; if (a_input !== a || b_input !== b) begin errors++; $display("FAIL rand_operands[%0d]: a=%h b=%h expected %h %h", i, a_input, b_input, a, b); end
    end
    mode_rand = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, ring, first;
    logic [15:0] g;
    for (int i = 0; i < 3; i++) begin
      g = 16'($urandom_range(0, 20));
      do_run($urandom, $urandom, g, -1, lat, ring, first);
      checks++; if (lat !== S + int'(g) + D + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, S + int'(g) + D + 1); end
    end
  endtask

  task automatic test_abort();
    int rc, cyc, exp_cnt;
    mode_rand = 1'b0;
    a_cfg = 32'h00001234; b_cfg = 32'h0000ABCD; gate_cycles = 16'd40;
    rise_q.delete(); start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_cfg = $urandom;
    rc = 0; cyc = 0;
    forever begin
      if (ring_en) rc++;
      if (rc == 5 || cyc > 100) break;
      @(negedge clk); cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    // Only rises old enough to clear the 3-cycle detect path were counted.
    exp_cnt = 0;
    foreach (rise_q[i]) if (rise_q[i] <= 3) exp_cnt++;
    checks++; if (ring_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop: ring_en=%b busy=%b expected 0 0", ring_en, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (count !== 32'(exp_cnt)) begin errors++; $display("FAIL abort_partial: got %0d expected %0d", count, exp_cnt); end
    checks++; if (a_input !== 32'h00001234) begin errors++; $display("FAIL abort_operand_hold: got %h expected 00001234", a_input); end
    a_cfg = 32'h00000055; gate_cycles = 16'd8; rise_q.delete(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 32'd0 || a_input !== 32'h00000055) begin errors++; $display("FAIL abort_restart: busy=%b count=%0d a=%h expected 1 0 00000055", busy, count, a_input); end
    cyc = 0;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (done !== 1'b1 || count !== 32'(rise_q.size())) begin errors++; $display("FAIL abort_rerun: done=%b count=%0d expected 1 %0d", done, count, rise_q.size()); end
  endtask

  task automatic test_priority();
    int lat, ring, first, rc, cyc, exp_cnt;
    mode_rand = 1'b0;
    do_run(32'h0F0F0F0F, 32'h1, 16'd20, 10, lat, ring, first);
    checks++; if (lat !== S + 20 + D + 1 || ring !== 20) begin errors++; $display("FAIL busy_start: lat=%0d ring=%0d expected %0d 20", lat, ring, S + 20 + D + 1); end
    checks++; if (count !== 32'(rise_q.size()) || a_input !== 32'h0F0F0F0F) begin errors++; $display("FAIL busy_start_data: count=%0d a=%h expected %0d 0f0f0f0f", count, a_input, rise_q.size()); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL start_abort_pair: busy=%b done=%b expected 0 1", busy, done); end
    start = 1'b1; active = 1'b0;
    @(negedge clk);
    start = 1'b0; active = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inactive_start: busy=%b expected 0", busy); end
    gate_cycles = 16'd30; rise_q.delete(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rc = 0; cyc = 0;
    forever begin
      if (ring_en) rc++;
      if (rc == 3 || cyc > 100) break;
      @(negedge clk); cyc++;
    end
    active = 1'b0;
    @(negedge clk);
    active = 1'b1;
    exp_cnt = 0;
    foreach (rise_q[i]) if (rise_q[i] <= 1) exp_cnt++;
    checks++; if (ring_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL inactive_abort: ring_en=%b busy=%b done=%b expected 000", ring_en, busy, done); end
    checks++; if (count !== 32'(exp_cnt)) begin errors++; $display("FAIL inactive_partial: got %0d expected %0d", count, exp_cnt); end
  endtask

  task automatic test_saturation();
    int lat, ring, first, n;
    mode_rand = 1'b0;
    do_run(32'h1, 32'h2, 16'd100, -1, lat, ring, first);
    n = rise_q.size();
    checks++; if (count !== 32'(n) || n != 25) begin errors++; $display("FAIL sat_wide_count: got %0d expected 25", count); end
    checks++; if (s_count !== 4'd15 || s_overflow !== 1'b1) begin errors++; $display("FAIL sat_narrow: count=%0d ovf=%b expected 15 1", s_count, s_overflow); end
    checks++; if (overflow !== 1'b0 || s_done !== 1'b1) begin errors++; $display("FAIL sat_flags: wide_ovf=%b narrow_done=%b expected 0 1", overflow, s_done); end
  endtask

  task automatic test_reset_mid_run();
    a_cfg = 32'hDEADBEEF; b_cfg = 32'hCAFEF00D; gate_cycles = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (a_input !== 32'd0 || b_input !== 32'd0 || busy !== 1'b0 || ring_en !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: a=%h b=%h busy=%b ring_en=%b expected 0", a_input, b_input, busy, ring_en); end
    checks++; if (done !== 1'b0 || count !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_status: done=%b count=%0d ovf=%b expected 0", done, count, overflow); end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0 || ring_en !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: busy=%b ring_en=%b expected 0 0", busy, ring_en); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_gate();
    test_random();
    test_back_to_back();
    test_abort();
    test_priority();
    test_saturation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_measure_sequencer.md
# adder_measure_sequencer

Sequences one delay measurement of the instrumented Kogge-Stone adder. It loads operands, lets them settle, and gates the adder's ring oscillator for a programmed number of clock cycles. During the gate it counts rising edges of `chain_out` and reports the count through a busy/done handshake. It sits inside the wrapped adder project between the logic-analyser register bank and the adder instance, and replaces direct LA control of operands and ring enable.

## Interface
Parameters:
- `WIDTH`, 32, operand width
- `CNT_W`, 32, edge-counter width
- `GATE_W`, 16, gate-length field width
- `SETTLE_CYCLES`, 4, operand settle time before ring enable (≥1)
- `DRAIN_CYCLES`, 3, post-gate counting time covering synchroniser latency (≥3)

Ports:
- `wb_clk_i` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `active` in 1: project select; low forces idle
- `start` in 1: single-cycle request
- `abort` in 1: cancel run in progress
- `a_cfg` in WIDTH: operand A
- `b_cfg` in WIDTH: operand B
- `gate_cycles` in GATE_W: ring-enable length
- `chain_out` in 1: ring output from adder, asynchronous
- `a_input` out WIDTH: operand A to adder
- `b_input` out WIDTH: operand B to adder
- `ring_en` out 1: closes ring loop
- `busy` out 1: run in progress
- `done` out 1: sticky, last run completed
- `count` out CNT_W: measured edge count
- `overflow` out 1: count saturated

## Operation
- States are IDLE, LOAD, SETTLE, RUN and DRAIN. All outputs are registered.
- **Reset values:** state IDLE; a_input=0; b_input=0; ring_en=0; busy=0; done=0; count=0; overflow=0; synchroniser flops 0.
- **IDLE → LOAD:** when `start & active & ~abort`.
  - done is cleared.
  - a_cfg, b_cfg and gate_cycles are latched.
  - count and overflow are cleared in LOAD.
- **LOAD → SETTLE:** after one cycle.
- **SETTLE → RUN:** after SETTLE_CYCLES cycles.
  - If the latched gate is 0, SETTLE goes straight to DRAIN.
- **RUN → DRAIN:** after exactly gate cycles.
- **DRAIN → IDLE:** after DRAIN_CYCLES cycles. done=1 is set on entry to IDLE.
- **ring_en:** 1 only while in RUN.
- **busy:** 1 in every state except IDLE.
- **Edge counting:**
  - chain_out passes through a 2-flop synchroniser, then a third flop for rising-edge detection.
  - count increments on a detected rise while state is RUN or DRAIN.
  - count saturates at all-ones and sets overflow.
- **Abort:** `abort` or `~active` in any non-IDLE state moves to IDLE on the next edge.
  - ring_en=0 and done stays 0.
  - count and overflow hold their partial values.
  - operands hold.
- **Start while busy:** ignored. In IDLE, start and abort in the same cycle means abort wins and no run starts.
- **Operand changes mid-run:** changes to cfg inputs during a run have no effect.
- **Reset mid-run:** reset returns all outputs to reset values on that edge.

## Timing
- Start is sampled at edge k:
  - LOAD after edge k;
  - RUN after edge k+2+SETTLE_CYCLES−1;
  - ring_en high for exactly G cycles;
  - done=1 and busy=0 visible after edge k+2+SETTLE_CYCLES+G+DRAIN_CYCLES−1.
- Total latency is SETTLE_CYCLES+G+DRAIN_CYCLES+1 cycles after the start edge. Defaults with G=10 give 18.
- A new start is accepted in the same cycle that done is visible.
- Edge-detect latency is 3 cycles; DRAIN_CYCLES≥3 guarantees every rise occurring during RUN is counted.
- Maximum countable rise rate is one per 2 clocks. Faster rings alias; this is documented, not flagged.

## Structure
- Package `adder_seq_pkg`:
  - state enum `seq_state_t`;
  - default constants for SETTLE_CYCLES and DRAIN_CYCLES.
- One sub-module, `sync_rise_detect`: 2-flop synchroniser plus edge flop, reset to 0, single-cycle `rise` output.
- The top level contains the FSM, the down-counter for settle/gate/drain, the operand registers and the saturating counter.

## Test plan
- **Basic run:**
  - Stimulus: reset, then start with a=0x0000FFFF, b=1, gate=40; bench toggles chain_out every 2 cycles while ring_en=1.
  - Required: ring_en high exactly 40 cycles; done after 48 cycles; count=10; a_input=0x0000FFFF.
- **Zero gate:**
  - Stimulus: gate=0.
  - Required: ring_en never rises; done after 8 cycles; count=0.
- **Abort:**
  - Stimulus: abort 5 cycles into RUN (gate=40).
  - Required: ring_en=0 and busy=0 next cycle; done=0; count = partial value; start 1 cycle later is accepted.
- **Ignored start and priority:**
  - Stimulus: start pulsed during RUN; start+abort together in IDLE; active=0 mid-run.
  - Required: the busy start has no effect; the simultaneous pair starts no run; active=0 aborts like abort.
- **Saturation:**
  - Stimulus: CNT_W=4, gate=100, chain_out toggling every 2 cycles.
  - Required: count=15, overflow=1.
- **Reset mid-run:**
  - Stimulus: rst_n=0 during SETTLE.
  - Required: all outputs at reset values on the next edge.
